// File: rtl/activation_writeback_pkg.sv
// Shared types and constants for the activation writeback path
// (accumulator -> activation/round/saturate -> unified buffer).
package act_pkg;

    typedef enum logic {
        ACT_NONE = 1'b0,
        ACT_RELU = 1'b1
    } act_func_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } wb_state_t;

    localparam int WB_FIFO_DEPTH = 2;
    localparam int MAX_ROWS      = 128;

endpackage

// File: rtl/activation_writeback_if.sv
// Accumulator read port and unified-buffer write port as seen by the writeback engine.
interface activation_writeback_if #(
    parameter int LANES  = 32,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ACC_AW = 7,
    parameter int UB_AW  = 12
) ();
    logic                          acc_rd_en_o;
    logic [ACC_AW-1:0]             acc_addr_rd_o;
    logic [LANES-1:0][ACC_W-1:0]   acc_data_i;
    logic                          ub_write_o;
    logic [UB_AW-1:0]              ub_addr_wr_o;
    logic [LANES-1:0][OUT_W-1:0]   ub_data_o;
    logic                          ub_ready_i;

    modport master (
        output acc_rd_en_o, acc_addr_rd_o, ub_write_o, ub_addr_wr_o, ub_data_o,
        input  acc_data_i, ub_ready_i
    );

    modport slave (
        input  acc_rd_en_o, acc_addr_rd_o, ub_write_o, ub_addr_wr_o, ub_data_o,
        output acc_data_i, ub_ready_i
    );
endinterface

// File: rtl/activation_writeback_fifo.sv
// Two-entry skid FIFO holding converted rows ({ub address, lane data}) ahead of the UB port.
module wb_skid_fifo
    import act_pkg::*;
#(
    parameter int W = 524
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [WB_FIFO_DEPTH];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push, do_pop;

    assign full_o  = (cnt_q == 2'(WB_FIFO_DEPTH));
    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < WB_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/activation_writeback.sv
// Drains accumulator rows into the unified buffer: ReLU/pass, rounding shift,
// saturation to OUT_W, with a credit-limited read pipeline feeding a skid FIFO.
module activation_writeback
    import act_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ACC_AW = 7,
    parameter int UB_AW  = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ACC_AW-1:0]     acc_base_addr_i,
    input  logic [UB_AW-1:0]      ub_base_addr_i,
    input  logic [7:0]            num_rows_i,
    input  act_func_t             act_func_i,
    input  logic [4:0]            shift_i,
    activation_writeback_if.master bus,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] x,
                                              input act_func_t f, input logic [4:0] s);
        logic signed [ACC_W:0] v, rnd, y;
        v = $signed({x[ACC_W-1], x});
        if (f == ACT_RELU && x[ACC_W-1]) v = '0;
        if (s != 5'd0) begin
            rnd = $signed((ACC_W+1)'(1) << (s - 5'd1));
            y   = (v + rnd) >>> s;
        end else begin
            y = v;
        end
        if (y > SAT_MAX) return SAT_MAX[OUT_W-1:0];
        if (y < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        return y[OUT_W-1:0];
    endfunction

    wb_state_t         state_q, state_d;
    logic [ACC_AW-1:0] acc_base_q, acc_base_d;
    logic [UB_AW-1:0]  ub_base_q, ub_base_d;
    logic [7:0]        num_rows_q, num_rows_d, issued_q, issued_d, written_q, written_d;
    act_func_t         act_q, act_d;
    logic [4:0]        shift_q, shift_d;
    logic              zero_done_q, zero_done_d;
    logic              rd_vld_q;
    logic [UB_AW-1:0]  pipe_addr_q;

    logic                        rd_en, pop, fifo_full, fifo_empty;
    logic [1:0]                  fifo_cnt, pending;
    logic [LANES-1:0][OUT_W-1:0] conv_row;
    logic [UB_AW+LANES*OUT_W-1:0] fifo_dout;

    // Outstanding rows once this cycle's pop leaves; keeps full rate with the UB ready.
    assign pending = 2'(rd_vld_q) + fifo_cnt - 2'(pop);
    assign pop     = !fifo_empty && bus.ub_ready_i;

    always_comb begin
        state_d     = state_q;
        acc_base_d  = acc_base_q;
        ub_base_d   = ub_base_q;
        num_rows_d  = num_rows_q;
        act_d       = act_q;
        shift_d     = shift_q;
        issued_d    = issued_q;
        written_d   = pop ? written_q + 8'd1 : written_q;
        zero_done_d = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) begin
                if (num_rows_i == 8'd0) begin
                    zero_done_d = 1'b1;
                end else begin
                    acc_base_d = acc_base_addr_i;
                    ub_base_d  = ub_base_addr_i;
                    num_rows_d = (num_rows_i > 8'(MAX_ROWS)) ? 8'(MAX_ROWS) : num_rows_i;
                    act_d      = act_func_i;
                    shift_d    = shift_i;
                    issued_d   = 8'd0;
                    written_d  = 8'd0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: if (issued_q < num_rows_q && pending < 2'd2 && !fifo_full) begin
                rd_en    = 1'b1;
                issued_d = issued_q + 8'd1;
                if (issued_q + 8'd1 == num_rows_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (written_q == num_rows_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            acc_base_q  <= '0;
            ub_base_q   <= '0;
            num_rows_q  <= '0;
            act_q       <= ACT_NONE;
            shift_q     <= '0;
            issued_q    <= '0;
            written_q   <= '0;
            zero_done_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            pipe_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_base_q  <= acc_base_d;
            ub_base_q   <= ub_base_d;
            num_rows_q  <= num_rows_d;
            act_q       <= act_d;
            shift_q     <= shift_d;
            issued_q    <= issued_d;
            written_q   <= written_d;
            zero_done_q <= zero_done_d;
            rd_vld_q    <= rd_en;
            if (rd_en) pipe_addr_q <= ub_base_q + UB_AW'(issued_q);
        end
    end

    always_comb begin
        conv_row = '0;
        for (int l = 0; l < LANES; l++) conv_row[l] = conv(bus.acc_data_i[l], act_q, shift_q);
    end

    wb_skid_fifo #(.W(UB_AW + LANES*OUT_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rd_vld_q),
        .din_i   ({pipe_addr_q, conv_row}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign bus.acc_rd_en_o   = rd_en;
    assign bus.acc_addr_rd_o = rd_en ? acc_base_q + ACC_AW'(issued_q) : '0;
    assign bus.ub_write_o    = !fifo_empty;
    assign {bus.ub_addr_wr_o, bus.ub_data_o} = fifo_dout;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = zero_done_q || (state_q == ST_DRAIN && written_q == num_rows_q);
endmodule

// File: tb/tb_activation_writeback.sv
// Directed bench for activation_writeback with an accumulator memory model and UB write monitor.
module tb_activation_writeback;
    import act_pkg::*;
    localparam int LANES = 32, ACC_W = 32, OUT_W = 16, ACC_AW = 7, UB_AW = 12;

    logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [ACC_AW-1:0] acc_base = '0;
    logic [UB_AW-1:0]  ub_base = '0;
    logic [7:0]        nrows = '0;
    act_func_t         act = ACT_NONE;
    logic [4:0]        shift = '0;
    logic              busy, done;

    activation_writeback_if #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W),
                              .ACC_AW(ACC_AW), .UB_AW(UB_AW)) bus ();

    activation_writeback #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W),
                           .ACC_AW(ACC_AW), .UB_AW(UB_AW)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .acc_base_addr_i(acc_base),
        .ub_base_addr_i(ub_base), .num_rows_i(nrows), .act_func_i(act), .shift_i(shift),
        .bus(bus), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    logic [LANES-1:0][ACC_W-1:0] mem [128];
    always @(posedge clk) if (bus.acc_rd_en_o) bus.acc_data_i <= mem[bus.acc_addr_rd_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] wa[$];
    logic [15:0] w0[$], w1[$], w31[$];
    logic [6:0]  ra[$];
    int          wc[$], rc[$];
    int          done_cnt = 0, done_cyc = 0, max_out = 0, stab_err = 0, stall_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] st_addr;
    logic [15:0] st_d0;
    int          n_checks = 0, n_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && (!bus.ub_write_o || bus.ub_addr_wr_o !== st_addr ||
                               bus.ub_data_o[0] !== st_d0)) stab_err++;
            prev_stall = bus.ub_write_o && !bus.ub_ready_i;
            if (prev_stall) begin
                stall_cnt++;
                st_addr = bus.ub_addr_wr_o;
                st_d0   = bus.ub_data_o[0];
            end
            if (ra.size() - wa.size() > max_out) max_out = ra.size() - wa.size();
            if (bus.acc_rd_en_o) begin ra.push_back(bus.acc_addr_rd_o); rc.push_back(cyc); end
            if (bus.ub_write_o && bus.ub_ready_i) begin
                wa.push_back(bus.ub_addr_wr_o);
                w0.push_back(bus.ub_data_o[0]);
                w1.push_back(bus.ub_data_o[1]);
                w31.push_back(bus.ub_data_o[31]);
                wc.push_back(cyc);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa.delete(); w0.delete(); w1.delete(); w31.delete(); wc.delete();
        ra.delete(); rc.delete();
        done_cnt = 0; max_out = 0; stab_err = 0; stall_cnt = 0; prev_stall = 1'b0;
    endtask

    task automatic go(input logic [6:0] a, input logic [11:0] u, input logic [7:0] n,
                      input act_func_t f, input logic [4:0] s);
        @(posedge clk); #1;
        acc_base = a; ub_base = u; nrows = n; act = f; shift = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, "_done_seen"}, 32'(i < 400), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"},   32'(bus.acc_rd_en_o), 32'd0);
        chk({tag, "_rd_addr"}, 32'(bus.acc_addr_rd_o), 32'd0);
        chk({tag, "_wr"},      32'(bus.ub_write_o), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.ub_addr_wr_o), 32'd0);
        chk({tag, "_wr_data"}, 32'(|bus.ub_data_o), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
    endtask

    initial begin
        for (int r = 0; r < 128; r++) begin
            mem[r]    = '0;
            mem[r][0] = 32'(r);
        end
        bus.ub_ready_i = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1 chk_idle_outputs("reset");
        rst_n = 1'b1;

        // 1: pass-through, latency and done timing
        mem[3][0] = 32'd100; mem[4][0] = 32'hFFFF_FFFB; mem[5][0] = 32'd0; mem[6][0] = 32'd32767;
        clr();
        go(7'd3, 12'd10, 8'd4, ACT_NONE, 5'd0);
        wait_done("t1");
        chk("t1_nwr", wa.size(), 4);
        chk("t1_rd0", 32'(ra[0]), 32'd3);
        chk("t1_rd3", 32'(ra[3]), 32'd6);
        chk("t1_wa0", 32'(wa[0]), 32'd10);
        chk("t1_wa3", 32'(wa[3]), 32'd13);
        chk("t1_d0",  32'(w0[0]), 32'h0064);
        chk("t1_d1",  32'(w0[1]), 32'hFFFB);
        chk("t1_d2",  32'(w0[2]), 32'h0000);
        chk("t1_d3",  32'(w0[3]), 32'h7FFF);
        chk("t1_lat", 32'(wc[0] - rc[0]), 32'd2);
        chk("t1_done_lat", 32'(done_cyc - wc[3]), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // 2: ReLU and rounding shift
        mem[20][0] = 32'hFFFF_FF9C; mem[21][0] = 32'd40; mem[22][0] = 32'd24;
        clr();
        go(7'd20, 12'd50, 8'd3, ACT_RELU, 5'd4);
        wait_done("t2r");
        chk("t2r_d0", 32'(w0[0]), 32'h0000);
        chk("t2r_d1", 32'(w0[1]), 32'h0003);
        chk("t2r_d2", 32'(w0[2]), 32'h0002);
        clr();
        go(7'd20, 12'd50, 8'd3, ACT_NONE, 5'd4);
        wait_done("t2n");
        chk("t2n_d0", 32'(w0[0]), 32'hFFFA);
        chk("t2n_d1", 32'(w0[1]), 32'h0003);
        chk("t2n_d2", 32'(w0[2]), 32'h0002);

        // 3: saturation and extreme shift
        mem[30][0] = 32'h7FFF_FFFF; mem[31][0] = 32'hFFFE_7960;
        mem[32][0] = 32'h4000_0000; mem[32][1] = 32'h7FFF_FFFF; mem[32][31] = 32'h8000_0000;
        clr();
        go(7'd30, 12'd60, 8'd2, ACT_NONE, 5'd0);
        wait_done("t3a");
        chk("t3_satpos", 32'(w0[0]), 32'h7FFF);
        chk("t3_satneg", 32'(w0[1]), 32'h8000);
        clr();
        go(7'd32, 12'd62, 8'd1, ACT_NONE, 5'd31);
        wait_done("t3b");
        chk("t3_sh31_l0",  32'(w0[0]), 32'h0001);
        chk("t3_sh31_l1",  32'(w1[0]), 32'h0001);
        chk("t3_sh31_l31", 32'(w31[0]), 32'hFFFF);

        // 4: backpressure
        for (int k = 0; k < 16; k++) mem[40 + k][0] = 32'(1000 + k);
        clr();
        go(7'd40, 12'd100, 8'd16, ACT_NONE, 5'd0);
        repeat (4) @(posedge clk);
        #1 bus.ub_ready_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.ub_ready_i = 1'b1;
        wait_done("t4");
        chk("t4_nwr", wa.size(), 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t4_wa%0d", k), 32'(wa[k]), 32'(100 + k));
            chk($sformatf("t4_d%0d", k),  32'(w0[k]), 32'(1000 + k));
        end
        chk("t4_max_out_le2", 32'(max_out <= 2), 32'd1);
        chk("t4_stall_cycles", stall_cnt, 5);
        chk("t4_stable", stab_err, 0);
        chk("t4_done_cnt", done_cnt, 1);

        // 5: address wrap
        mem[126][0] = 32'd11; mem[127][0] = 32'd12; mem[0][0] = 32'd13; mem[1][0] = 32'd14;
        clr();
        go(7'd126, 12'd4094, 8'd4, ACT_NONE, 5'd0);
        wait_done("t5");
        chk("t5_rd2", 32'(ra[2]), 32'd0);
        chk("t5_rd3", 32'(ra[3]), 32'd1);
        chk("t5_wa1", 32'(wa[1]), 32'd4095);
        chk("t5_wa2", 32'(wa[2]), 32'd0);
        chk("t5_wa3", 32'(wa[3]), 32'd1);
        chk("t5_d0",  32'(w0[0]), 32'd11);
        chk("t5_d3",  32'(w0[3]), 32'd14);

        // 6a: zero-row job
        clr();
        @(posedge clk); #1 nrows = 8'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("t6a_done_next", 32'(done), 32'd1);
        @(posedge clk); #1 chk("t6a_done_pulse", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t6a_no_rd", ra.size(), 0);
        chk("t6a_no_wr", wa.size(), 0);
        chk("t6a_busy", 32'(busy), 32'd0);

        // 6b: start while busy is ignored
        clr();
        go(7'd50, 12'd200, 8'd8, ACT_NONE, 5'd0);
        repeat (3) @(posedge clk);
        #1 nrows = 8'd2; ub_base = 12'd900; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("t6b");
        repeat (6) @(posedge clk);
        #1;
        chk("t6b_nwr", wa.size(), 8);
        chk("t6b_wa0", 32'(wa[0]), 32'd200);
        chk("t6b_wa7", 32'(wa[7]), 32'd207);
        chk("t6b_done_cnt", done_cnt, 1);

        // 6c: reset mid-job
        clr();
        go(7'd60, 12'd300, 8'd16, ACT_NONE, 5'd0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_idle_outputs("t6c_rst");
        clr();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("t6c_no_wr", wa.size(), 0);
        chk("t6c_no_rd", ra.size(), 0);
        chk("t6c_no_done", done_cnt, 0);

        // 6d: normal job after reset
        clr();
        go(7'd3, 12'd10, 8'd4, ACT_NONE, 5'd0);
        wait_done("t6d");
        chk("t6d_nwr", wa.size(), 4);
        chk("t6d_d1", 32'(w0[1]), 32'hFFFB);
        chk("t6d_d3", 32'(w0[3]), 32'h7FFF);

        // 7: num_rows above 128 clamps to 128
        clr();
        go(7'd0, 12'd0, 8'd200, ACT_NONE, 5'd0);
        wait_done("t7");
        chk("t7_nwr", wa.size(), 128);
        chk("t7_wa_last", 32'(wa[127]), 32'd127);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
